input_conditioner: RTL
======================

# input_conditioner

Parametrised multi-channel input conditioner for the lock's keypad and button inputs. Each asynchronous input goes through a configurable-depth synchronizer chain, then a per-channel debounce counter. The block emits a stable debounced level and a single-cycle rising-edge pulse per channel. It sits between the board pins and the lock FSM, replacing the bare two-flop synchronizer on every input.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchronizer flops per channel (≥2)
- DB_CYCLES, 16, consecutive cycles a new level must be held before it is accepted (≥1)
- RESET_LEVEL, 1'b0, value loaded into all sync flops and debounced state at reset
- clk  input  1  system clock; all flops on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sig_in  input  CHANNELS  raw asynchronous inputs
- sig_sync  output  CHANNELS  last synchronizer stage, undebounced
- sig_db  output  CHANNELS  debounced level
- rise_pulse  output  CHANNELS  one-cycle pulse on each 0→1 change of sig_db
- fall_pulse  output  CHANNELS  one-cycle pulse on each 1→0 change of sig_db (only with INCOND_FALL_EDGE_EN)

## Operation
- Channels are fully independent; no cross-channel state.
- Synchronizer: shift chain of SYNC_STAGES flops; sig_sync is the last stage.
- Debounce per channel: counter of width $clog2(DB_CYCLES+1), plus state bit db.
  - If sig_sync == db: the counter clears to 0.
  - If sig_sync != db and count < DB_CYCLES-1: the counter increments.
  - If sig_sync != db and count == DB_CYCLES-1: db toggles and the counter clears.
  - Any return to the db level before the count completes discards the progress, so a glitch never leaks through.
- rise_pulse is registered. It is 1 in exactly the cycle where db first reads 1, and 0 otherwise.
- fall_pulse follows the same rule for the cycle where db first reads 0.
- Counter never wraps; its maximum value is DB_CYCLES-1.

## Timing
- Reset values:
  - sync flops = RESET_LEVEL
  - sig_db = RESET_LEVEL
  - counters = 0
  - rise_pulse = 0, fall_pulse = 0
- No pulse is generated at reset release, even if sig_in differs from RESET_LEVEL.
  - The difference is debounced normally and pulses when accepted.
- Latency, for an input stable before edge 1:
  - sig_sync changes at edge SYNC_STAGES.
  - sig_db and the pulse change at edge SYNC_STAGES+DB_CYCLES.
- Minimum accepted pulse width is DB_CYCLES cycles of synchronized level.
- Reset asserted mid-count clears all state immediately and asynchronously. After release, a full count is needed.
- DB_CYCLES=1: sig_db follows sig_sync one cycle later.

## Configuration
- INCOND_FALL_EDGE_EN defined: the fall_pulse port and its registers exist, with behaviour as above.
- INCOND_FALL_EDGE_EN undefined: the fall_pulse port is absent and no falling-edge logic is built. All other outputs are identical in both builds.

## Structure
- Package incond_pkg holds:
  - default parameter constants (DEF_SYNC_STAGES, DEF_DB_CYCLES)
  - counter-width function cnt_w(db_cycles)
- Sub-module debounce_channel: one synchronizer chain plus counter, db bit and pulse flops.
  - input_conditioner instantiates it CHANNELS times in a generate loop.

## Test plan
Defaults for all scenarios unless stated: CHANNELS=4, SYNC_STAGES=2, DB_CYCLES=4, RESET_LEVEL=0, macro defined.

- Reset/latency: hold rst_n=0 with sig_in=4'hF, then release.
  - All outputs stay 0 during reset.
  - sig_sync=4'hF at edge 2; sig_db=4'hF at edge 6.
  - rise_pulse=4'hF for exactly one cycle.
- Glitch reject: sig_in[0] high for 3 cycles, then low.
  - sig_sync[0] is high for 3 cycles.
  - sig_db[0] stays 0; rise_pulse[0] never asserts.
- Bounce: sig_in[1] toggles 1,0,1,1,0, then holds 1.
  - sig_db[1] rises once, 4 cycles after sig_sync[1] settles.
  - Exactly one rise_pulse[1].
- Simultaneous channels: with sig_db=4'b0100, change sig_in to 4'b0010 in one cycle.
  - rise_pulse[1] and fall_pulse[2] assert in the same cycle.
  - Channels 0 and 3 are unaffected.
- Reset mid-count: pull rst_n low while the channel-3 counter is 3.
  - All state clears.
  - After release with sig_in[3] still 1, sig_db[3] rises at edge 6.
- Macro off: rebuild without INCOND_FALL_EDGE_EN and rerun scenarios 1–3.
  - Identical sig_sync, sig_db and rise_pulse traces.
  - No fall_pulse port.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner (package incond_pkg).
// The optional falling-edge output is built when INCOND_FALL_EDGE_EN is defined.
package incond_pkg;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 16;

    // Width of a counter that must reach db_cycles-1 without wrapping.
    function automatic int cnt_w(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: synchronizer chain, debounce counter, level and edge pulses.
// The falling-edge pulse register exists only when INCOND_FALL_EDGE_EN is defined.
module debounce_channel
    import incond_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   DB_CYCLES   = DEF_DB_CYCLES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_sync,
    output logic sig_db,
    output logic rise_pulse
`ifdef INCOND_FALL_EDGE_EN
    ,
    output logic fall_pulse
`endif
);

    localparam int CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   db_r;
    logic                   db_nxt_s;
    logic                   toggle_s;
    logic                   sync_last_s;
    logic                   rise_r;
`ifdef INCOND_FALL_EDGE_EN
    logic                   fall_r;
`endif

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Synchronizer shift chain; bit 0 samples the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Debounce decision: any return to the held level discards progress.
    always_comb begin
        cnt_nxt_s = cnt_r;
        toggle_s  = 1'b0;
        if (sync_last_s == db_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r >= CNT_MAX) begin
            toggle_s  = 1'b1;
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
        db_nxt_s = db_r ^ toggle_s;
    end

    // Counter, accepted level and edge pulses, all updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            db_r   <= RESET_LEVEL;
            rise_r <= 1'b0;
`ifdef INCOND_FALL_EDGE_EN
            fall_r <= 1'b0;
`endif
        end else begin
            cnt_r  <= cnt_nxt_s;
            db_r   <= db_nxt_s;
            rise_r <= toggle_s & ~db_r;
`ifdef INCOND_FALL_EDGE_EN
            fall_r <= toggle_s & db_r;
`endif
        end
    end

    assign sig_sync   = sync_last_s;
    assign sig_db     = db_r;
    assign rise_pulse = rise_r;
`ifdef INCOND_FALL_EDGE_EN
    assign fall_pulse = fall_r;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchronizer + debouncer for keypad and button pins.
// Define INCOND_FALL_EDGE_EN to add the fall_pulse output.
module input_conditioner
    import incond_pkg::*;
#(
    parameter int   CHANNELS    = DEF_CHANNELS,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   DB_CYCLES   = DEF_DB_CYCLES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_sync,
    output logic [CHANNELS-1:0] sig_db,
    output logic [CHANNELS-1:0] rise_pulse
`ifdef INCOND_FALL_EDGE_EN
    ,
    output logic [CHANNELS-1:0] fall_pulse
`endif
);

    // Channels share nothing but clock and reset.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_in     (sig_in[gi]),
            .sig_sync   (sig_sync[gi]),
            .sig_db     (sig_db[gi]),
            .rise_pulse (rise_pulse[gi])
`ifdef INCOND_FALL_EDGE_EN
            ,
            .fall_pulse (fall_pulse[gi])
`endif
        );
    end

endmodule
